pulse_interval_monitor: RTL and testbench
=========================================

Name: pulse_interval_monitor

Overview:
- Receive-side checker for the periodic single-cycle pulse train produced by the team's synchronous pulse generator.
- Measures the cycle count between rising edges of the incoming pulse and checks it against an expected interval with a tolerance window.
- Declares lock after N consecutive in-window intervals and flags out-of-window intervals and missing pulses.
- Sits in the same clock domain as the generator; used for self-test and link-health status.

Parameters:
EXPECTED_INTERVAL  10  nominal cycles between rising edges (>= 2)
TOLERANCE          1   allowed +/- deviation in cycles (< EXPECTED_INTERVAL)
LOCK_COUNT         4   consecutive good intervals required to assert locked (>= 1)

Ports:
clk            input   1  system clock, rising edge
reset_n        input   1  asynchronous, active-low reset
enable         input   1  monitor enable
pulse_in       input   1  pulse train under test, synchronous to clk
edge_seen      output  1  one-cycle strobe per detected rising edge
interval       output  CW measured cycles between the last two edges; CW = $clog2(EXPECTED_INTERVAL+TOLERANCE+2)
interval_valid output  1  one-cycle strobe: interval updated
window_err     output  1  one-cycle strobe: measured interval outside [EXP-TOL, EXP+TOL]
timeout_err    output  1  one-cycle strobe: no edge within EXP+TOL+1 cycles
locked         output  1  level: LOCK_COUNT consecutive good intervals seen, no error since

Behaviour:
- Reset (reset_n low, async): all outputs 0, interval 0, p_d 0, cnt 0, good_cnt 0, state IDLE. Reset mid-operation aborts lock immediately.
- Edge detect: edge = pulse_in & ~p_d. p_d <= pulse_in every cycle, including when enable = 0. A pulse held high for several cycles counts as one edge.
- All outputs are registered. Strobes assert the cycle after pulse_in is first sampled high.
- cnt counts cycles since the last edge:
  - on an edge: cnt <= 1
  - otherwise: cnt <= cnt + 1, saturating at EXP+TOL+1
- States: IDLE (no reference edge), ACQUIRE (measuring, not locked), LOCKED.
- IDLE:
  - Edge -> ACQUIRE, edge_seen = 1, no interval_valid, good_cnt = 0.
  - cnt holds at 0 in IDLE.
- ACQUIRE / LOCKED, edge:
  - interval <= cnt, interval_valid = 1, edge_seen = 1.
  - If EXP-TOL <= cnt <= EXP+TOL: good_cnt++ (saturating at LOCK_COUNT). When good_cnt reaches LOCK_COUNT -> LOCKED, locked = 1 in the same cycle as that interval_valid.
  - Otherwise: window_err = 1, good_cnt = 0, go to (or stay in) ACQUIRE, locked = 0 in the same cycle. The edge still restarts measurement.
- ACQUIRE / LOCKED, no edge and cnt == EXP+TOL+1: timeout_err = 1 for one cycle, state -> IDLE, locked = 0, good_cnt = 0, cnt = 0.
- Simultaneous edge and cnt == EXP+TOL+1: the edge wins. Result is window_err with interval = EXP+TOL+1 and no timeout_err.
- enable low: state -> IDLE, cnt = 0, good_cnt = 0, locked = 0, all strobes 0, interval holds its last value. After re-enable, the first edge is a reference edge only.
- Strobes are mutually consistent:
  - interval_valid implies edge_seen.
  - window_err implies interval_valid.
  - timeout_err never coincides with edge_seen.

Test Plan:
(Defaults EXP=10, TOL=1, LOCK=4 unless noted.)
1. Reset: assert reset_n low mid-stream with pulses running -> all outputs 0 immediately, asynchronously. After release, the first edge gives edge_seen only.
2. Six 1-cycle pulses spaced 10 cycles apart:
   - interval_valid on pulses 2..6, each with interval = 10.
   - locked rises with the pulse-5 interval_valid and stays 1.
   - No window_err or timeout_err.
3. While locked, inject a pulse 8 cycles after the previous one:
   - window_err = 1, interval = 8, locked falls the same cycle.
   - Four further 10-cycle intervals re-assert locked.
4. Window boundaries: intervals of 9 and 11 accepted with no error. An interval of exactly 12 gives window_err with interval = 12 and no timeout_err.
5. Stop pulses while locked:
   - timeout_err fires once, 12 cycles after the last edge.
   - locked drops; state returns to IDLE.
   - The next pulse gives edge_seen with no interval_valid.
6. pulse_in held high for 5 cycles every 10 cycles -> behaves identically to 1-cycle pulses (interval = 10, lock after 5 edges). Dropping enable for 3 cycles while locked clears locked and requires full reacquisition.

Source files
------------

// File: rtl/pulse_interval_monitor.sv
// ---------------------------------------------------------------------------
// pulse_interval_monitor
//
// Receive-side checker for a periodic single-cycle pulse train generated in
// the same clock domain. It measures the number of cycles between rising
// edges of pulse_in and compares each measurement against
// EXPECTED_INTERVAL +/- TOLERANCE. After LOCK_COUNT consecutive in-window
// intervals it reports lock. Out-of-window intervals and missing pulses
// raise one-cycle error strobes and drop lock.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   monitor enable; low forces IDLE and clears lock
//   pulse_in       in   pulse train under test, synchronous to clk
//   edge_seen      out  one-cycle strobe per detected rising edge
//   interval       out  cycles between the last two edges (holds between)
//   interval_valid out  one-cycle strobe: interval was updated
//   window_err     out  one-cycle strobe: interval outside the window
//   timeout_err    out  one-cycle strobe: no edge within EXP+TOL+1 cycles
//   locked         out  level: LOCK_COUNT good intervals, no error since
//
// All outputs are registered, so every strobe appears the cycle after
// pulse_in is first sampled high.
// ---------------------------------------------------------------------------
module pulse_interval_monitor #(
    parameter int EXPECTED_INTERVAL = 10,
    parameter int TOLERANCE         = 1,
    parameter int LOCK_COUNT        = 4,
    localparam int CW = $clog2(EXPECTED_INTERVAL + TOLERANCE + 2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          pulse_in,
    output logic          edge_seen,
    output logic [CW-1:0] interval,
    output logic          interval_valid,
    output logic          window_err,
    output logic          timeout_err,
    output logic          locked
);

    localparam int WIN_LO  = EXPECTED_INTERVAL - TOLERANCE;
    localparam int WIN_HI  = EXPECTED_INTERVAL + TOLERANCE;
    localparam int MAX_CNT = EXPECTED_INTERVAL + TOLERANCE + 1;
    localparam int GW      = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   good_q, good_d;
    logic [CW-1:0]   interval_q, interval_d;
    logic            edge_seen_q, edge_seen_d;
    logic            interval_valid_q, interval_valid_d;
    logic            window_err_q, window_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            locked_q, locked_d;

    logic            edge_det;
    logic            in_window;

    assign edge_det  = pulse_in & ~p_q;
    assign in_window = (cnt_q >= CW'(WIN_LO)) && (cnt_q <= CW'(WIN_HI));

    always_comb begin
        state_d          = state_q;
        p_d              = pulse_in;   // tracks the input even while disabled
        cnt_d            = cnt_q;
        good_d           = good_q;
        interval_d       = interval_q;
        edge_seen_d      = 1'b0;
        interval_valid_d = 1'b0;
        window_err_d     = 1'b0;
        timeout_err_d    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            good_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (edge_det) begin
                        // Reference edge only: starts measurement, no interval.
                        state_d     = ACQUIRE;
                        edge_seen_d = 1'b1;
                        cnt_d       = CW'(1);
                        good_d      = '0;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    if (edge_det) begin
                        // An edge always beats a coincident timeout; the
                        // saturated count then lands outside the window.
                        edge_seen_d      = 1'b1;
                        interval_valid_d = 1'b1;
                        interval_d       = cnt_q;
                        cnt_d            = CW'(1);
                        if (in_window) begin
                            if (good_q >= GW'(LOCK_COUNT - 1)) begin
                                good_d  = GW'(LOCK_COUNT);
                                state_d = LOCKED;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end else begin
                            window_err_d = 1'b1;
                            good_d       = '0;
                            state_d      = ACQUIRE;
                        end
                    end else if (cnt_q == CW'(MAX_CNT)) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                        good_d        = '0;
                        cnt_d         = '0;
                    end else begin
                        // The count never passes MAX_CNT: reaching it
                        // without an edge takes the timeout branch above.
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            p_q              <= 1'b0;
            cnt_q            <= '0;
            good_q           <= '0;
            interval_q       <= '0;
            edge_seen_q      <= 1'b0;
            interval_valid_q <= 1'b0;
            window_err_q     <= 1'b0;
            timeout_err_q    <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            p_q              <= p_d;
            cnt_q            <= cnt_d;
            good_q           <= good_d;
            interval_q       <= interval_d;
            edge_seen_q      <= edge_seen_d;
            interval_valid_q <= interval_valid_d;
            window_err_q     <= window_err_d;
            timeout_err_q    <= timeout_err_d;
            locked_q         <= locked_d;
        end
    end

    assign edge_seen      = edge_seen_q;
    assign interval       = interval_q;
    assign interval_valid = interval_valid_q;
    assign window_err     = window_err_q;
    assign timeout_err    = timeout_err_q;
    assign locked         = locked_q;

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// ---------------------------------------------------------------------------
// tb_pulse_interval_monitor
//
// Directed bench for pulse_interval_monitor with EXP=10, TOL=1, LOCK=4.
// Inputs change 1 ns after a rising clock edge; outputs are sampled at the
// same point, so each observation reflects the edge that just occurred.
// Every cycle is compared as one packed vector
// {edge_seen, interval_valid, window_err, timeout_err, locked, interval}.
// ---------------------------------------------------------------------------
module tb_pulse_interval_monitor;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          pulse_in;
    logic          edge_seen;
    logic [CW-1:0] interval;
    logic          interval_valid;
    logic          window_err;
    logic          timeout_err;
    logic          locked;

    int n_cmp = 0;
    int n_err = 0;

    pulse_interval_monitor #(
        .EXPECTED_INTERVAL (10),
        .TOLERANCE         (1),
        .LOCK_COUNT        (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .pulse_in       (pulse_in),
        .edge_seen      (edge_seen),
        .interval       (interval),
        .interval_valid (interval_valid),
        .window_err     (window_err),
        .timeout_err    (timeout_err),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] v(input logic es, input logic iv,
                                     input logic we, input logic te,
                                     input logic lk, input logic [3:0] ival);
        return {es, iv, we, te, lk, ival};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {edge_seen, interval_valid, window_err, timeout_err, locked, interval};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed es/iv/we/te/lk/int=%b required=%b", tag, obs, exp);
        end
    endtask

    // One rising edge of pulse_in, then check the strobes it produces.
    task automatic edge_step(input string tag, input logic iv, input logic we,
                             input logic lk, input logic [3:0] ival);
        pulse_in = 1'b1;
        tick();
        check(tag, v(1'b1, iv, we, 1'b0, lk, ival));
        $display("edge %s: interval=%0d iv=%b we=%b te=%b locked=%b",
                 tag, interval, interval_valid, window_err, timeout_err, locked);
    endtask

    // n cycles without a new edge; pulse_in stays high for the first 'high'
    // of them (a wide pulse). No strobes expected, locked/interval steady.
    task automatic quiet(input string tag, input int n, input int high,
                         input logic lk, input logic [3:0] ival);
        for (int i = 0; i < n; i++) begin
            pulse_in = (i < high);
            tick();
            check(tag, v(1'b0, 1'b0, 1'b0, 1'b0, lk, ival));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        pulse_in = 1'b0;
        repeat (3) tick();
        check("reset_state", 9'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        quiet("settle", 2, 0, 1'b0, 4'd0);

        // Six pulses 10 apart: lock with the 5th pulse.
        edge_step("p1_ref", 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 2; k <= 6; k++) begin
            quiet("gap", 9, 0, (k >= 6), (k == 2) ? 4'd0 : 4'd10);
            edge_step($sformatf("p%0d", k), 1'b1, 1'b0, (k >= 5), 4'd10);
        end

        // Short interval while locked, then reacquire.
        quiet("gap_short", 7, 0, 1'b1, 4'd10);
        edge_step("short8", 1'b1, 1'b1, 1'b0, 4'd8);
        for (int k = 1; k <= 4; k++) begin
            quiet("gap_relock", 9, 0, 1'b0, (k == 1) ? 4'd8 : 4'd10);
            edge_step($sformatf("relock%0d", k), 1'b1, 1'b0, (k == 4), 4'd10);
        end

        // Window boundaries: 9 and 11 good, 12 is a window error (no timeout).
        quiet("gap9", 8, 0, 1'b1, 4'd10);
        edge_step("int9", 1'b1, 1'b0, 1'b1, 4'd9);
        quiet("gap11", 10, 0, 1'b1, 4'd9);
        edge_step("int11", 1'b1, 1'b0, 1'b1, 4'd11);
        quiet("gap12", 11, 0, 1'b1, 4'd11);
        edge_step("int12", 1'b1, 1'b1, 1'b0, 4'd12);

        // Relock, then stop pulses: timeout 12 cycles after the last edge.
        for (int k = 1; k <= 4; k++) begin
            quiet("gap_lock5", 9, 0, 1'b0, (k == 1) ? 4'd12 : 4'd10);
            edge_step($sformatf("lock5_%0d", k), 1'b1, 1'b0, (k == 4), 4'd10);
        end
        quiet("pre_timeout", 11, 0, 1'b1, 4'd10);
        pulse_in = 1'b0;
        tick();
        check("timeout", v(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10));
        $display("timeout: te=%b locked=%b", timeout_err, locked);
        quiet("post_timeout", 5, 0, 1'b0, 4'd10);
        edge_step("ref_after_to", 1'b0, 1'b0, 1'b0, 4'd10);

        // Wide (5-cycle) pulses every 10 cycles: lock after 5 edges.
        for (int k = 1; k <= 4; k++) begin
            quiet("gap_wide", 9, 4, 1'b0, 4'd10);
            edge_step($sformatf("wide%0d", k), 1'b1, 1'b0, (k == 4), 4'd10);
        end
        quiet("wide_tail", 4, 4, 1'b1, 4'd10);

        // Drop enable for 3 cycles; an edge inside that window is ignored.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_in = (i == 1);
            tick();
            check("disabled", v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10));
        end
        enable = 1'b1;
        quiet("reenable", 3, 0, 1'b0, 4'd10);
        edge_step("reen_ref", 1'b0, 1'b0, 1'b0, 4'd10);
        for (int k = 1; k <= 4; k++) begin
            quiet("gap_reen", 9, 4, 1'b0, 4'd10);
            edge_step($sformatf("reen%0d", k), 1'b1, 1'b0, (k == 4), 4'd10);
        end

        // Asynchronous reset mid-stream while locked.
        quiet("pre_reset", 3, 3, 1'b1, 4'd10);
        reset_n = 1'b0;
        #1;
        check("async_reset", 9'd0);
        $display("async reset: locked=%b interval=%0d", locked, interval);
        tick();
        tick();
        check("reset_hold", 9'd0);
        reset_n = 1'b1;
        quiet("after_reset", 2, 0, 1'b0, 4'd0);
        edge_step("rst_ref", 1'b0, 1'b0, 1'b0, 4'd0);
        quiet("gap_rst", 9, 0, 1'b0, 4'd0);
        edge_step("rst_first", 1'b1, 1'b0, 1'b0, 4'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
